// File: rtl/clk_div.sv
// Integer clock divider: clk_out is low for floor(DIV/2) cycles, then high for ceil(DIV/2) cycles.
// Output comes straight from a flop, so there is no input-to-output path; no handshake, always running.
module clk_div #(
  parameter int DIV   = 4,
  parameter int CNT_W = ($clog2(DIV) < 1) ? 1 : $clog2(DIV)
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_out
);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("clk_div: DIV must be at least 2");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Explicit compare against DIV-1 keeps non-power-of-two ratios from reaching unused codes.
  always_comb begin
    cnt_next = cnt + CNT_W'(1);
    if (cnt == CNT_LAST) begin
      cnt_next = '0;
    end
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      clk_out <= (cnt_next >= CNT_HALF);
    end
  end

endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div at ratios 4, 5 and 2, each instance with its own reset.
module tb_clk_div;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst4, rst5, rst2;
  logic out4, out5, out2;

  clk_div #(.DIV(4)) dut4 (.clk(clk), .rst_n(rst4), .clk_out(out4));
  clk_div #(.DIV(5)) dut5 (.clk(clk), .rst_n(rst5), .clk_out(out5));
  clk_div #(.DIV(2)) dut2 (.clk(clk), .rst_n(rst2), .clk_out(out2));

  int checks   = 0;
  int failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst4 = 1'b1; rst5 = 1'b1; rst2 = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      checks++;
      if (out4 !== 1'b0 || out5 !== 1'b0 || out2 !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold edge %0d: out4=%b out5=%b out2=%b expected all 0", e, out4, out5, out2);
      end
      checks++;
      if (int'(dut4.cnt) != 0 || int'(dut5.cnt) != 0 || int'(dut2.cnt) != 0) begin
        failures++;
        $display("FAIL reset_cnt edge %0d: cnt4=%0d cnt5=%0d cnt2=%0d expected 0", e, dut4.cnt, dut5.cnt, dut2.cnt);
      end
    end
  endtask

  task automatic test_steady_div4();
    int  pat[4] = '{0, 1, 1, 0};
    int  cnt_exp[4] = '{1, 2, 3, 0};
    logic prev;
    time last_rise;
    int  rises;
    prev = 1'b0; last_rise = 0; rises = 0;
    rst4 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      checks++;
      if (out4 !== 1'(pat[(k-1)%4])) begin
        failures++;
        $display("FAIL div4_pattern edge %0d: got %b expected %0d", k, out4, pat[(k-1)%4]);
      end
      checks++;
      if (int'(dut4.cnt) != cnt_exp[(k-1)%4]) begin
        failures++;
        $display("FAIL div4_cnt edge %0d: got %0d expected %0d", k, dut4.cnt, cnt_exp[(k-1)%4]);
      end
      if (prev == 1'b0 && out4 == 1'b1) begin
        if (rises > 0) begin
          checks++;
          if ($time - last_rise != 80) begin
            failures++;
            $display("FAIL div4_period: got %0t expected 80", $time - last_rise);
          end
        end
        last_rise = $time;
        rises++;
      end
      if (prev == 1'b1 && out4 == 1'b0) begin
        checks++;
        if ($time - last_rise != 40) begin
          failures++;
          $display("FAIL div4_high_time: got %0t expected 40", $time - last_rise);
        end
      end
      prev = out4;
    end
    checks++;
    if (rises != 10) begin
      failures++;
      $display("FAIL div4_rise_count: got %0d expected 10", rises);
    end
  endtask

  task automatic test_odd_div5();
    int  pat[5] = '{0, 1, 1, 1, 0};
    logic prev;
    time last_rise;
    int  rises;
    prev = 1'b0; last_rise = 0; rises = 0;
    rst5 = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      step();
      checks++;
      if (out5 !== 1'(pat[(k-1)%5])) begin
        failures++;
        $display("FAIL div5_pattern edge %0d: got %b expected %0d", k, out5, pat[(k-1)%5]);
      end
      checks++;
      if (int'(dut5.cnt) > 4 || int'(dut5.cnt) != k % 5) begin
        failures++;
        $display("FAIL div5_cnt edge %0d: got %0d expected %0d", k, dut5.cnt, k % 5);
      end
      if (prev == 1'b0 && out5 == 1'b1) begin
        if (rises > 0) begin
          checks++;
          if ($time - last_rise != 100) begin
            failures++;
            $display("FAIL div5_period: got %0t expected 100", $time - last_rise);
          end
        end
        last_rise = $time;
        rises++;
      end
      if (prev == 1'b1 && out5 == 1'b0) begin
        checks++;
        if ($time - last_rise != 60) begin
          failures++;
          $display("FAIL div5_high_time: got %0t expected 60", $time - last_rise);
        end
      end
      prev = out5;
    end
    checks++;
    if (rises != 10) begin
      failures++;
      $display("FAIL div5_rise_count: got %0d expected 10", rises);
    end
  endtask

  task automatic test_min_div2();
    rst2 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (out2 !== 1'(k % 2)) begin
        failures++;
        $display("FAIL div2_toggle edge %0d: got %b expected %0d", k, out2, k % 2);
      end
    end
  endtask

  task automatic test_mid_reset();
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    step(); step(); step();
    checks++;
    if (out4 !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_pre: got %b expected 1", out4);
    end
    rst4 = 1'b1;
    step();
    checks++;
    if (out4 !== 1'b0 || int'(dut4.cnt) != 0) begin
      failures++;
      $display("FAIL mid_reset_edge: out=%b cnt=%0d expected out=0 cnt=0", out4, dut4.cnt);
    end
    rst4 = 1'b0;
    step();
    checks++;
    if (out4 !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_edge1: got %b expected 0", out4);
    end
    step();
    checks++;
    if (out4 !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_edge2: got %b expected 1", out4);
    end
  endtask

  task automatic test_wrap_reset();
    int pat[4] = '{0, 1, 1, 0};
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    step(); step(); step();
    checks++;
    if (int'(dut4.cnt) != 3) begin
      failures++;
      $display("FAIL wrap_pre_cnt: got %0d expected 3", dut4.cnt);
    end
    rst4 = 1'b1;
    step();
    checks++;
    if (out4 !== 1'b0 || int'(dut4.cnt) != 0) begin
      failures++;
      $display("FAIL wrap_reset_edge: out=%b cnt=%0d expected out=0 cnt=0", out4, dut4.cnt);
    end
    rst4 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (out4 !== 1'(pat[(k-1)%4]) || int'(dut4.cnt) != k % 4) begin
        failures++;
        $display("FAIL wrap_resume edge %0d: out=%b cnt=%0d expected out=%0d cnt=%0d",
                 k, out4, dut4.cnt, pat[(k-1)%4], k % 4);
      end
    end
  endtask

  initial begin
    rst4 = 1'b1; rst5 = 1'b1; rst2 = 1'b1;
    test_reset();
    test_steady_div4();
    test_odd_div5();
    test_min_div2();
    test_mid_reset();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
